ttl_pulse_gen: RTL
==================

Name: ttl_pulse_gen

Overview:
- Transmit-side counterpart of the channel-2 TTL trigger detector: synthesises a TTL-like rectangular pulse as a DAC sample stream on an AXI4-Stream master.
- The detector on the receive path recognises the pulse with its 54/50 hysteresis thresholds, which lets the trigger loop be exercised end-to-end.
- Sits between the control register block, which supplies start/delay/width/holdoff, and the DAC output stream at 125 MHz.

Parameters:
- DAC_WIDTH, 10, DAC code width; code occupies tdata[AXIS_TDATA_WIDTH-1 -: DAC_WIDTH], remaining LSBs zero.
- AXIS_TDATA_WIDTH, 16, stream data width.
- CNT_WIDTH, 32, width of delay/width/holdoff counters.
- HIGH_CODE, 200, signed DAC code driven during the pulse; must map above the detector's upper threshold.
- LOW_CODE, 0, signed DAC code driven outside the pulse.

Ports:
- clk  input  1  125 MHz clock
- rst  input  1  synchronous reset, active-low
- start  input  1  single-cycle request to emit one pulse
- delay_cycles  input  CNT_WIDTH  low beats between start and the pulse rising edge
- width_cycles  input  CNT_WIDTH  high beats; 0 is treated as 1
- holdoff_cycles  input  CNT_WIDTH  low beats after the falling edge before re-arm
- M_AXIS_OUT_tdata  output  AXIS_TDATA_WIDTH  DAC sample
- M_AXIS_OUT_tvalid  output  1  stream valid
- M_AXIS_OUT_tready  input  1  DAC ready
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, all counters 0, tdata=LOW_CODE placement, tvalid=0, busy=0, done=0.
  - Reset mid-pulse aborts immediately; the next sample is low.
- tvalid:
  - Goes to 1 on the first clk edge with rst==1 and stays 1; the DAC stream is continuous.
  - tdata holds until a beat is accepted (tvalid & tready).
- Beats: all counters advance only on accepted beats. While tready=0, state and tdata are frozen and time is stretched.
- Configuration latch: delay/width/holdoff are latched when start is accepted in IDLE. Later changes do not affect the pulse in flight.
- FSM (registered, one process for state, one for next-state):
  - IDLE: output LOW_CODE. start=1 moves to DELAY if delay>0, else to PULSE. start is ignored in every other state; there is no queueing.
  - DELAY: output LOW_CODE. After delay accepted beats, move to PULSE.
  - PULSE: output HIGH_CODE. After max(width,1) accepted beats, move to HOLDOFF if holdoff>0, else to IDLE.
  - HOLDOFF: output LOW_CODE. After holdoff accepted beats, move to IDLE.
- tdata is registered from the next-state decode. With tready=1 continuously, the first high sample appears on tdata on the clk edge after start is sampled plus delay cycles.
- Counters use down-count from the latched value; terminal count is 1. No wrap: a max-value load counts fully.
- done: asserted for exactly one clk on the edge where the state becomes IDLE from PULSE or HOLDOFF. It is not asserted after reset.
- start during reset is ignored.

Optional Feature:
- Macro TTL_PULSE_PERIODIC_EN.
- When defined: adds input port run (1 bit). While run=1, IDLE re-launches a pulse automatically each time it is entered, as if start were asserted with the current config inputs. This gives a period of delay+width+holdoff beats (width treated as ≥1). Deasserting run lets the current pulse finish normally; the block then stays in IDLE. done still pulses on each IDLE entry.
- When undefined: run port absent; only start launches pulses.

Test Plan:
- Reset release, tready=1, no start: tvalid rises 1 cycle after rst→1; tdata=0x0000 indefinitely; busy=0, done never asserts.
- start with delay=3, width=5, holdoff=2, tready=1: tdata shows 3×0x0000, 5×0x3200 (200<<6), 2×0x0000. busy is high for 10 cycles, then done high for 1 cycle.
- Same pulse with tready held 0 for 4 cycles mid-PULSE: high segment spans 9 clk but exactly 5 accepted beats; tdata stable while stalled.
- delay=0, width=0, holdoff=0: exactly 1 high beat on the cycle after start, then IDLE; done fires once.
- start re-asserted during PULSE and config changed mid-pulse: no second pulse and original width preserved. rst=0 mid-PULSE: next tdata=0x0000, tvalid=0, busy=0.
- (TTL_PULSE_PERIODIC_EN) run=1 with delay=2, width=4, holdoff=4: pulses repeat every 10 beats. Drop run mid-HOLDOFF: exactly one more done, then idle.

Source files
------------

// File: rtl/ttl_pulse_gen.sv
// TTL-like pulse synthesiser on a continuous DAC AXI4-Stream.
// Optional TTL_PULSE_PERIODIC_EN adds a run input for automatic re-launch.
module ttl_pulse_gen #(
  parameter int DAC_WIDTH        = 10,
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int CNT_WIDTH        = 32,
  parameter int HIGH_CODE        = 200,
  parameter int LOW_CODE         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef TTL_PULSE_PERIODIC_EN
  input  logic                        run,
`endif
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        delay_cycles,
  input  logic [CNT_WIDTH-1:0]        width_cycles,
  input  logic [CNT_WIDTH-1:0]        holdoff_cycles,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        busy,
  output logic                        done
);

  localparam int PAD = AXIS_TDATA_WIDTH - DAC_WIDTH;
  localparam logic [DAC_WIDTH-1:0] HI_C = DAC_WIDTH'(HIGH_CODE);
  localparam logic [DAC_WIDTH-1:0] LO_C = DAC_WIDTH'(LOW_CODE);
  localparam logic [AXIS_TDATA_WIDTH-1:0] HI_W =
    AXIS_TDATA_WIDTH'(HI_C) << PAD;
  localparam logic [AXIS_TDATA_WIDTH-1:0] LO_W =
    AXIS_TDATA_WIDTH'(LO_C) << PAD;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PULSE,
    HOLDOFF
  } state_e;

  state_e                      state_q, state_d, ld_state;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        wid_q, wid_d;
  logic [CNT_WIDTH-1:0]        hold_q, hold_d;
  logic [CNT_WIDTH-1:0]        ld_wid, ld_cnt;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, code_d;
  logic                        tvalid_q;
  logic                        done_q, done_d;
  logic                        beat, launch, relaunch, fin;

  assign beat = tvalid_q & M_AXIS_OUT_tready;

`ifdef TTL_PULSE_PERIODIC_EN
  assign launch   = start | run;
  assign relaunch = run;
`else
  assign launch   = start;
  assign relaunch = 1'b0;
`endif

  // Width of zero still yields one high beat
  assign ld_wid   = (width_cycles == '0) ? ONE : width_cycles;
  assign ld_state = (delay_cycles != '0) ? DELAY : PULSE;
  assign ld_cnt   = (delay_cycles != '0) ? delay_cycles : ld_wid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    if (beat) begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            state_d = ld_state;
            cnt_d   = ld_cnt;
            wid_d   = ld_wid;
            hold_d  = holdoff_cycles;
          end
        end
        DELAY: begin
          if (cnt_q == ONE) begin
            state_d = PULSE;
            cnt_d   = wid_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        PULSE: begin
          if (cnt_q == ONE) begin
            if (hold_q != '0) begin
              state_d = HOLDOFF;
              cnt_d   = hold_q;
            end else begin
              fin = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        HOLDOFF: begin
          if (cnt_q == ONE) fin = 1'b1;
          else cnt_d = cnt_q - ONE;
        end
        default: state_d = IDLE;
      endcase
      if (fin) begin
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        // Periodic mode passes through IDLE without spending a beat there
        if (relaunch) begin
          state_d = ld_state;
          cnt_d   = ld_cnt;
          wid_d   = ld_wid;
          hold_d  = holdoff_cycles;
        end
      end
    end
  end

  assign code_d = (state_d == PULSE) ? HI_W : LO_W;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wid_q    <= '0;
      hold_q   <= '0;
      tdata_q  <= LO_W;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wid_q    <= wid_d;
      hold_q   <= hold_d;
      tvalid_q <= 1'b1;
      done_q   <= done_d;
      if (beat) tdata_q <= code_d;
    end
  end

  assign M_AXIS_OUT_tdata  = tdata_q;
  assign M_AXIS_OUT_tvalid = tvalid_q;
  assign busy              = (state_q != IDLE);
  assign done              = done_q;

endmodule
